// File: rtl/risc_spm_core_if.sv
// risc_spm_core_if
// Memory bus between the SPM core and its single-port memory.
// The core is the master: it raises mem_req with a stable address and
// direction and holds them until the memory answers with mem_ack.
//   mem_req   : access request, held until acknowledged
//   mem_we    : 1 = write, 0 = read, meaningful while mem_req is high
//   mem_addr  : access address
//   mem_wdata : write data
//   mem_rdata : read data, used only in the acknowledging cycle
//   mem_ack   : access completes at the rising edge where req and ack are both high
interface risc_spm_core_if #(
    parameter int WORD_SIZE = 8
);
    logic                 mem_req;
    logic                 mem_we;
    logic [WORD_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic [WORD_SIZE-1:0] mem_rdata;
    logic                 mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/risc_spm_core.sv
// risc_spm_core
// Parametrised RISC stored-program-machine core: register file, ALU,
// Z/C flags, program counter and a multi-state controller fetching and
// executing from an external memory through a req/ack handshake.
// WORD_SIZE must be at least 4 + 2*REG_BITS so the instruction fields fit.
//   clk        : single clock, rising edge
//   rst        : synchronous active-low reset
//   bus        : memory master port (req/we/addr/wdata out, rdata/ack in)
//   pc_out     : current program counter
//   zero_flag  : Z flag
//   carry_flag : C flag
//   halted     : core sits in HALT
//   illegal_op : sticky, HALT was reached through an undefined opcode
module risc_spm_core #(
    parameter int WORD_SIZE = 8,
    parameter int REG_BITS  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    risc_spm_core_if.master        bus,
    output logic [WORD_SIZE-1:0]   pc_out,
    output logic                   zero_flag,
    output logic                   carry_flag,
    output logic                   halted,
    output logic                   illegal_op
);

    localparam int NUM_REGS = 2 ** REG_BITS;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_NOT = 4'd4;
    localparam logic [3:0] OP_RD  = 4'd5;
    localparam logic [3:0] OP_WR  = 4'd6;
    localparam logic [3:0] OP_BR  = 4'd7;
    localparam logic [3:0] OP_BRZ = 4'd8;
    localparam logic [3:0] OP_OR  = 4'd9;
    localparam logic [3:0] OP_XOR = 4'd10;
    localparam logic [3:0] OP_SHL = 4'd11;
    localparam logic [3:0] OP_BRC = 4'd12;
    localparam logic [3:0] OP_HLT = 4'd15;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DEC,
        S_EX,
        S_ADDR,
        S_RD,
        S_WR,
        S_BR,
        S_HALT
    } state_t;

    state_t state;
    state_t state_next;

    logic [WORD_SIZE-1:0] regs [NUM_REGS];
    logic [WORD_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0] ir;
    logic [WORD_SIZE-1:0] ar;
    logic [WORD_SIZE-1:0] y;
    logic                 z;
    logic                 c;
    logic                 ill;

    logic [3:0]           opcode;
    logic [REG_BITS-1:0]  src;
    logic [REG_BITS-1:0]  dest;
    logic [WORD_SIZE-1:0] src_val;
    logic [WORD_SIZE-1:0] dest_val;
    logic [WORD_SIZE-1:0] not_val;
    logic [WORD_SIZE:0]   alu_wide;
    logic [WORD_SIZE-1:0] alu_res;
    logic                 alu_carry;

    assign opcode   = ir[WORD_SIZE-1 -: 4];
    assign src      = ir[2*REG_BITS-1:REG_BITS];
    assign dest     = ir[REG_BITS-1:0];
    assign src_val  = regs[src];
    assign dest_val = regs[dest];
    assign not_val  = ~src_val;

    // ALU evaluated one bit wider than the word: the extra MSB is the
    // carry-out for ADD and the borrow for SUB (the subtraction wraps
    // exactly when R[dest] < Y); for SHL it catches the bit shifted out.
    always_comb begin
        alu_wide = '0;
        case (opcode)
            OP_ADD:  alu_wide = {1'b0, dest_val} + {1'b0, y};
            OP_SUB:  alu_wide = {1'b0, dest_val} - {1'b0, y};
            OP_AND:  alu_wide = {1'b0, dest_val & y};
            OP_OR:   alu_wide = {1'b0, dest_val | y};
            OP_XOR:  alu_wide = {1'b0, dest_val ^ y};
            OP_SHL:  alu_wide = {dest_val, 1'b0};
            default: alu_wide = '0;
        endcase
    end

    assign alu_res   = alu_wide[WORD_SIZE-1:0];
    assign alu_carry = alu_wide[WORD_SIZE];

    // Controller state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Memory states only advance on mem_ack, which is
    // what stretches them by the wait cycles the memory inserts.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  state_next = S_FETCH;
            S_FETCH: if (bus.mem_ack) state_next = S_DEC;
            S_DEC: begin
                case (opcode)
                    OP_NOP:  state_next = S_FETCH;
                    OP_ADD, OP_SUB, OP_AND,
                    OP_OR, OP_XOR, OP_SHL:
                             state_next = S_EX;
                    OP_NOT:  state_next = S_FETCH;
                    OP_RD, OP_WR:
                             state_next = S_ADDR;
                    OP_BR:   state_next = S_BR;
                    OP_BRZ:  state_next = z ? S_BR : S_FETCH;
                    OP_BRC:  state_next = c ? S_BR : S_FETCH;
                    OP_HLT:  state_next = S_HALT;
                    default: state_next = S_HALT;
                endcase
            end
            S_EX:    state_next = S_FETCH;
            S_ADDR:  if (bus.mem_ack) state_next = (opcode == OP_WR) ? S_WR : S_RD;
            S_RD:    if (bus.mem_ack) state_next = S_FETCH;
            S_WR:    if (bus.mem_ack) state_next = S_FETCH;
            S_BR:    if (bus.mem_ack) state_next = S_FETCH;
            S_HALT:  state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
    end

    // Bus outputs depend only on state and registers, so address and data
    // stay put for the whole stalled access. The request is gated with
    // rst so it drops in the very cycle reset is asserted.
    always_comb begin
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (state)
            S_FETCH, S_ADDR, S_BR: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = pc;
            end
            S_RD: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = ar;
            end
            S_WR: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = ar;
                bus.mem_wdata = src_val;
            end
            default: ;
        endcase
        if (!rst) begin
            bus.mem_req = 1'b0;
        end
    end

    // Datapath: register file, PC, IR, AR, Y and flags. Every memory-fed
    // update is qualified by mem_ack so a stalled access changes nothing.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            pc  <= '0;
            ir  <= '0;
            ar  <= '0;
            y   <= '0;
            z   <= 1'b0;
            c   <= 1'b0;
            ill <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (bus.mem_ack) begin
                        ir <= bus.mem_rdata;
                        pc <= pc + WORD_SIZE'(1);
                    end
                end
                S_DEC: begin
                    case (opcode)
                        OP_ADD, OP_SUB, OP_AND,
                        OP_OR, OP_XOR, OP_SHL:
                            y <= src_val;
                        OP_NOT: begin
                            regs[dest] <= not_val;
                            z          <= (not_val == '0);
                        end
                        OP_BRZ: if (!z) pc <= pc + WORD_SIZE'(1);
                        OP_BRC: if (!c) pc <= pc + WORD_SIZE'(1);
                        OP_NOP, OP_RD, OP_WR, OP_BR, OP_HLT: ;
                        default: ill <= 1'b1;
                    endcase
                end
                S_EX: begin
                    regs[dest] <= alu_res;
                    z          <= (alu_res == '0);
                    if (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_SHL) begin
                        c <= alu_carry;
                    end
                end
                S_ADDR: begin
                    if (bus.mem_ack) begin
                        ar <= bus.mem_rdata;
                        pc <= pc + WORD_SIZE'(1);
                    end
                end
                S_RD: begin
                    if (bus.mem_ack) begin
                        regs[dest] <= bus.mem_rdata;
                    end
                end
                S_BR: begin
                    if (bus.mem_ack) begin
                        pc <= bus.mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pc_out     = pc;
    assign zero_flag  = z;
    assign carry_flag = c;
    assign halted     = (state == S_HALT);
    assign illegal_op = ill;

endmodule

// File: tb/tb_risc_spm_core.sv
// tb_risc_spm_core
// Directed bench for risc_spm_core: an 8-bit/4-register core on a memory
// model with programmable wait states, plus a 16-bit/8-register core on a
// zero-wait memory running the load/add/store program through R7.
module tb_risc_spm_core;

    logic clk = 1'b0;
    logic rst;
    logic rst2;

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    risc_spm_core_if #(.WORD_SIZE(8))  bus ();
    risc_spm_core_if #(.WORD_SIZE(16)) bus16 ();

    logic [7:0]  pc_out;
    logic        zero_flag, carry_flag, halted, illegal_op;
    logic [15:0] pc_out2;
    logic        zero_flag2, carry_flag2, halted2, illegal_op2;

    risc_spm_core #(.WORD_SIZE(8), .REG_BITS(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .pc_out     (pc_out),
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag),
        .halted     (halted),
        .illegal_op (illegal_op)
    );

    risc_spm_core #(.WORD_SIZE(16), .REG_BITS(3)) dut16 (
        .clk        (clk),
        .rst        (rst2),
        .bus        (bus16),
        .pc_out     (pc_out2),
        .zero_flag  (zero_flag2),
        .carry_flag (carry_flag2),
        .halted     (halted2),
        .illegal_op (illegal_op2)
    );

    int checks   = 0;
    int failures = 0;

    // 8-bit memory model with a wait-state counter: ack comes after
    // wait_cycles stalled cycles, or is tied high for zero-wait operation.
    logic [7:0] mem [256];
    int         wait_cycles = 0;
    int         wait_cnt    = 0;
    logic       mem_clr     = 1'b0;
    logic       pre_we      = 1'b0;
    logic [7:0] pre_addr    = '0;
    logic [7:0] pre_data    = '0;

    assign bus.mem_ack   = (wait_cycles == 0) ? 1'b1 : (bus.mem_req && (wait_cnt == wait_cycles));
    assign bus.mem_rdata = mem[bus.mem_addr];

    // Wait counter restarts whenever no access is pending or one completes.
    always @(posedge clk) begin
        if (!bus.mem_req || bus.mem_ack) wait_cnt <= 0;
        else                             wait_cnt <= wait_cnt + 1;
    end

    // Single writer for the 8-bit memory: bench clear, bench preload, core writes.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (bus.mem_req && bus.mem_ack && bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    // 16-bit zero-wait memory.
    logic [15:0] mem16 [65536];
    logic        pre16_we   = 1'b0;
    logic [15:0] pre16_addr = '0;
    logic [15:0] pre16_data = '0;

    assign bus16.mem_ack   = 1'b1;
    assign bus16.mem_rdata = mem16[bus16.mem_addr];

    // Single writer for the 16-bit memory.
    always @(posedge clk) begin
        if (pre16_we) begin
            mem16[pre16_addr] <= pre16_data;
        end else if (bus16.mem_req && bus16.mem_ack && bus16.mem_we) begin
            mem16[bus16.mem_addr] <= bus16.mem_wdata;
        end
    end

    // Request monitor: counts request cycles and, while enabled, compares
    // addr/we/wdata of each stalled request against the previous cycle.
    logic       stab_en         = 1'b0;
    logic       hold_valid      = 1'b0;
    logic       hold_we         = 1'b0;
    logic [7:0] hold_addr       = '0;
    logic [7:0] hold_wdata      = '0;
    int         stab_samples    = 0;
    int         stab_violations = 0;
    int         req_count       = 0;

    always @(negedge clk) begin
        if (bus.mem_req) req_count++;
        if (stab_en && hold_valid && bus.mem_req) begin
            stab_samples++;
            if (bus.mem_addr !== hold_addr || bus.mem_we !== hold_we ||
                (hold_we && bus.mem_wdata !== hold_wdata)) begin
                stab_violations++;
            end
        end
        hold_valid = bus.mem_req && !bus.mem_ack;
        hold_addr  = bus.mem_addr;
        hold_we    = bus.mem_we;
        hold_wdata = bus.mem_wdata;
    end

    // Hard stop if the run ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Holds the 8-bit core in reset for two edges with the given memory latency.
    task automatic applyStimulus(input int waits);
        rst         = 1'b0;
        wait_cycles = waits;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clearMem();
        mem_clr = 1'b1;
        step(1);
        mem_clr = 1'b0;
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        step(1);
        pre_we   = 1'b0;
    endtask

    task automatic poke16(input logic [15:0] a, input logic [15:0] d);
        pre16_addr = a;
        pre16_data = d;
        pre16_we   = 1'b1;
        step(1);
        pre16_we   = 1'b0;
    endtask

    // NOP; NOP; RD R0,[0x20]; RD R1,[0x21]; ADD R0->R1; WR R1->[0x22]; HLT
    task automatic loadProgram1();
        poke(8'h00, 8'h00);
        poke(8'h01, 8'h00);
        poke(8'h02, 8'h50);
        poke(8'h03, 8'h20);
        poke(8'h04, 8'h51);
        poke(8'h05, 8'h21);
        poke(8'h06, 8'h11);
        poke(8'h07, 8'h64);
        poke(8'h08, 8'h22);
        poke(8'h09, 8'hF0);
        poke(8'h20, 8'h05);
        poke(8'h21, 8'hFE);
    endtask

    int req_base;
    int samp_base;
    int viol_base;
    int budget;

    initial begin
        rst  = 1'b0;
        rst2 = 1'b0;

        // Reset in the middle of a stalled fetch (3 wait states).
        applyStimulus(3);
        clearMem();
        loadProgram1();
        rst = 1'b1;
        step(7);
        checkOutput("prereset_req", bus.mem_req, 1'b1);
        checkOutput("prereset_addr", bus.mem_addr, 8'h01);
        rst = 1'b0;
        #1;
        checkOutput("reset_req_comb", bus.mem_req, 1'b0);
        step(2);
        checkOutput("reset_pc", pc_out, 8'h00);
        checkOutput("reset_z", zero_flag, 1'b0);
        checkOutput("reset_c", carry_flag, 1'b0);
        checkOutput("reset_halted", halted, 1'b0);
        checkOutput("reset_illegal", illegal_op, 1'b0);
        checkOutput("reset_req", bus.mem_req, 1'b0);
        rst = 1'b1;
        step(1);
        checkOutput("restart_req", bus.mem_req, 1'b1);
        checkOutput("restart_addr", bus.mem_addr, 8'h00);

        // Load/add/store at zero wait: 22 cycles from release to HALT.
        applyStimulus(0);
        clearMem();
        loadProgram1();
        rst = 1'b1;
        step(21);
        checkOutput("p1_not_halted_21", halted, 1'b0);
        step(1);
        checkOutput("p1_halted_22", halted, 1'b1);
        checkOutput("p1_mem22", mem[8'h22], 8'h03);
        checkOutput("p1_c", carry_flag, 1'b1);
        checkOutput("p1_z", zero_flag, 1'b0);
        checkOutput("p1_pc", pc_out, 8'h0A);
        checkOutput("p1_hlt_illegal", illegal_op, 1'b0);
        req_base = req_count;
        step(10);
        checkOutput("p1_halt_no_req", req_count - req_base, 0);

        // Same program, 2 wait cycles per access: 13 memory states of 3 cycles.
        applyStimulus(2);
        clearMem();
        loadProgram1();
        samp_base = stab_samples;
        viol_base = stab_violations;
        stab_en   = 1'b1;
        rst       = 1'b1;
        step(47);
        checkOutput("ws_not_halted_47", halted, 1'b0);
        step(1);
        checkOutput("ws_halted_48", halted, 1'b1);
        stab_en = 1'b0;
        checkOutput("ws_mem22", mem[8'h22], 8'h03);
        checkOutput("ws_c", carry_flag, 1'b1);
        checkOutput("ws_z", zero_flag, 1'b0);
        checkOutput("ws_pc", pc_out, 8'h0A);
        checkOutput("ws_stability", stab_violations - viol_base, 0);
        checkOutput("ws_stall_samples", stab_samples - samp_base, 26);

        // Branches: RD R2=0xC0; ADD R2+R2; SUB R2-R2; BRC 0x50; BRZ 0x40; @0x40 HLT.
        applyStimulus(0);
        clearMem();
        poke(8'h00, 8'h52);
        poke(8'h01, 8'h30);
        poke(8'h02, 8'h1A);
        poke(8'h03, 8'h2A);
        poke(8'h04, 8'hC0);
        poke(8'h05, 8'h50);
        poke(8'h06, 8'h80);
        poke(8'h07, 8'h40);
        poke(8'h30, 8'hC0);
        poke(8'h40, 8'hF0);
        poke(8'h50, 8'hD0);
        rst = 1'b1;
        step(8);
        checkOutput("br_add_c", carry_flag, 1'b1);
        checkOutput("br_add_z", zero_flag, 1'b0);
        step(3);
        checkOutput("br_sub_z", zero_flag, 1'b1);
        checkOutput("br_sub_c", carry_flag, 1'b0);
        step(2);
        checkOutput("br_brc_not_taken_pc", pc_out, 8'h06);
        step(3);
        checkOutput("br_brz_taken_pc", pc_out, 8'h40);
        step(2);
        checkOutput("br_halted", halted, 1'b1);
        checkOutput("br_final_pc", pc_out, 8'h41);
        checkOutput("br_illegal", illegal_op, 1'b0);

        // SHL on R3=0x81, store R3, then opcode 13.
        applyStimulus(0);
        clearMem();
        poke(8'h00, 8'h53);
        poke(8'h01, 8'h30);
        poke(8'h02, 8'hB3);
        poke(8'h03, 8'h6C);
        poke(8'h04, 8'h31);
        poke(8'h05, 8'hD0);
        poke(8'h30, 8'h81);
        rst = 1'b1;
        step(8);
        checkOutput("shl_c", carry_flag, 1'b1);
        checkOutput("shl_z", zero_flag, 1'b0);
        step(6);
        checkOutput("ill13_halted", halted, 1'b1);
        checkOutput("ill13_illegal", illegal_op, 1'b1);
        checkOutput("shl_mem31", mem[8'h31], 8'h02);
        checkOutput("ill13_pc", pc_out, 8'h06);
        req_base = req_count;
        step(10);
        checkOutput("ill13_no_req", req_count - req_base, 0);

        // Opcode 14 traps as well; the following reset clears the sticky bit.
        applyStimulus(0);
        checkOutput("reset_clears_illegal", illegal_op, 1'b0);
        clearMem();
        poke(8'h00, 8'hE0);
        rst = 1'b1;
        step(3);
        checkOutput("ill14_halted", halted, 1'b1);
        checkOutput("ill14_illegal", illegal_op, 1'b1);
        checkOutput("ill14_pc", pc_out, 8'h01);

        // 16-bit build: same load/add/store program using R6 and R7.
        poke16(16'h0000, 16'h0000);
        poke16(16'h0001, 16'h0000);
        poke16(16'h0002, 16'h5006);
        poke16(16'h0003, 16'h0020);
        poke16(16'h0004, 16'h5007);
        poke16(16'h0005, 16'h0021);
        poke16(16'h0006, 16'h1037);
        poke16(16'h0007, 16'h6038);
        poke16(16'h0008, 16'h0022);
        poke16(16'h0009, 16'hF000);
        poke16(16'h0020, 16'h0005);
        poke16(16'h0021, 16'hFFFE);
        poke16(16'h0022, 16'h0000);
        rst2   = 1'b1;
        budget = 0;
        while (!halted2 && budget < 100) begin
            step(1);
            budget++;
        end
        checkOutput("w16_halted", halted2, 1'b1);
        checkOutput("w16_mem22", mem16[16'h0022], 16'h0003);
        checkOutput("w16_c", carry_flag2, 1'b1);
        checkOutput("w16_z", zero_flag2, 1'b0);
        checkOutput("w16_pc", pc_out2, 16'h000A);
        checkOutput("w16_illegal", illegal_op2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
